// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-port DP_mem32x64k array between instruction fetch and load/store,
// tracking the owner of the one-cycle-latency read so mem_q is flagged back to the right requester.
module mem_port_arbiter #(
    parameter int WORD         = 32,
    parameter int ADDR         = 16,
    parameter int STARVE_LIMIT = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            if_req,
    input  logic [ADDR-1:0] if_addr,
    output logic            if_gnt,
    output logic            if_rvalid,
    output logic [WORD-1:0] if_rdata,
    input  logic            ls_req,
    input  logic            ls_we,
    input  logic [ADDR-1:0] ls_addr,
    input  logic [WORD-1:0] ls_wdata,
    output logic            ls_gnt,
    output logic            ls_rvalid,
    output logic [WORD-1:0] ls_rdata,
    output logic [ADDR-1:0] mem_a,
    output logic            mem_w,
    output logic [WORD-1:0] mem_d,
    input  logic [WORD-1:0] mem_q
);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_LS   = 2'd2
    } own_e;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [3:0] starve_q, starve_d;
    own_e       own_q, own_d;
    logic       pri_if;

    // Fetch takes priority only in the single cycle the counter sits at the limit.
    always_comb begin
        pri_if = (starve_q == LIMIT);
        if (pri_if) begin
            if_gnt = if_req;
            ls_gnt = ls_req & ~if_req;
        end else begin
            ls_gnt = ls_req;
            if_gnt = if_req & ~ls_req;
        end
    end

    always_comb begin
        mem_a = '0;
        mem_w = 1'b0;
        mem_d = '0;
        if (if_gnt) begin
            mem_a = if_addr;
        end else if (ls_gnt) begin
            mem_a = ls_addr;
            mem_w = ls_we;
            mem_d = ls_wdata;
        end
    end

    always_comb begin
        starve_d = starve_q;
        if (if_gnt || !if_req) begin
            starve_d = '0;
        end else if (starve_q != LIMIT) begin
            starve_d = starve_q + 4'd1;
        end

        own_d = OWN_NONE;
        if (if_gnt) begin
            own_d = OWN_IF;
        end else if (ls_gnt && !ls_we) begin
            own_d = OWN_LS;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            starve_q <= '0;
            own_q    <= OWN_NONE;
        end else begin
            starve_q <= starve_d;
            own_q    <= own_d;
        end
    end

    assign if_rvalid = (own_q == OWN_IF);
    assign ls_rvalid = (own_q == OWN_LS);
    assign if_rdata  = mem_q;
    assign ls_rdata  = mem_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural one-cycle-latency memory attached.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req;
    logic [15:0] if_addr;
    logic        if_gnt, if_rvalid;
    logic [31:0] if_rdata;
    logic        ls_req, ls_we;
    logic [15:0] ls_addr;
    logic [31:0] ls_wdata;
    logic        ls_gnt, ls_rvalid;
    logic [31:0] ls_rdata;
    logic [15:0] mem_a;
    logic        mem_w;
    logic [31:0] mem_d;
    logic [31:0] mem_q;

    logic [31:0] mem [0:65535];

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    mem_port_arbiter #(.WORD(32), .ADDR(16), .STARVE_LIMIT(4)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
        .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata),
        .mem_a(mem_a), .mem_w(mem_w), .mem_d(mem_d), .mem_q(mem_q)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_w) mem[mem_a] <= mem_d;
        mem_q <= mem[mem_a];
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle's requests just after the edge, then settle before checking.
    task automatic drive(input logic ir, input logic [15:0] ia, input logic lr,
                         input logic lw, input logic [15:0] la, input logic [31:0] ld);
        @(posedge clk);
        #1;
        if_req = ir; if_addr = ia;
        ls_req = lr; ls_we = lw; ls_addr = la; ls_wdata = ld;
        #3;
    endtask

    initial begin
        logic prev_if, prev_ls, exp_if;

        for (int i = 0; i < 16; i++) mem[i] = 32'hA000_0000 | i;
        reset = 1'b1;
        if_req = 1'b0; if_addr = '0;
        ls_req = 1'b0; ls_we = 1'b0; ls_addr = '0; ls_wdata = '0;

        #2;
        chk("rst_if_rvalid", if_rvalid, 0);
        chk("rst_ls_rvalid", ls_rvalid, 0);
        chk("rst_if_gnt", if_gnt, 0);
        chk("rst_mem_a", mem_a, 0);
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;

        // IF only, addresses 0..3
        drive(1, 16'h0000, 0, 0, 0, 0);
        chk("if1_gnt", if_gnt, 1);
        chk("if1_ls_gnt", ls_gnt, 0);
        chk("if1_mem_a", mem_a, 16'h0000);
        chk("if1_mem_w", mem_w, 0);
        chk("if1_rvalid0", if_rvalid, 0);
        for (int k = 1; k < 4; k++) begin
            drive(1, 16'(k), 0, 0, 0, 0);
            chk("if1_gnt_k", if_gnt, 1);
            chk("if1_ls_gnt_k", ls_gnt, 0);
            chk("if1_mem_a_k", mem_a, 64'(k));
            chk("if1_rvalid_k", if_rvalid, 1);
            chk("if1_rdata_k", if_rdata, 64'(32'hA000_0000 + k - 1));
        end
        drive(0, 0, 0, 0, 0, 0);
        chk("if1_rvalid_last", if_rvalid, 1);
        chk("if1_rdata_last", if_rdata, 32'hA000_0003);
        chk("idle_if_gnt", if_gnt, 0);
        chk("idle_ls_gnt", ls_gnt, 0);
        chk("idle_ls_rvalid", ls_rvalid, 0);
        drive(0, 0, 0, 0, 0, 0);
        chk("if1_rvalid_off", if_rvalid, 0);

        // LS write then read of 0x0012
        drive(0, 0, 1, 1, 16'h0012, 32'hDEADBEEF);
        chk("ls_wr_gnt", ls_gnt, 1);
        chk("ls_wr_if_gnt", if_gnt, 0);
        chk("ls_wr_mem_w", mem_w, 1);
        chk("ls_wr_mem_a", mem_a, 16'h0012);
        chk("ls_wr_mem_d", mem_d, 32'hDEADBEEF);
        drive(0, 0, 1, 0, 16'h0012, 32'h0);
        chk("ls_rd_mem_w", mem_w, 0);
        chk("ls_rd_gnt", ls_gnt, 1);
        chk("ls_after_wr_rvalid", ls_rvalid, 0);
        chk("ls_after_wr_if_rvalid", if_rvalid, 0);
        drive(0, 0, 0, 0, 0, 0);
        chk("ls_rd_rvalid", ls_rvalid, 1);
        chk("ls_rd_rdata", ls_rdata, 32'hDEADBEEF);
        chk("ls_rd_if_rvalid", if_rvalid, 0);
        chk("idle_mem_w", mem_w, 0);
        chk("idle_mem_d", mem_d, 0);

        // Held contention: LS x4, IF x1, repeating
        prev_if = 1'b0; prev_ls = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        prev_ls = 1'b0;
        for (int i = 0; i < 10; i++) begin
            drive(1, 16'h0005, 1, 0, 16'h0006, 0);
            exp_if = ((i % 5) == 4);
            chk("cont_if_gnt", if_gnt, 64'(exp_if));
            chk("cont_ls_gnt", ls_gnt, 64'(!exp_if));
            chk("cont_excl", if_gnt & ls_gnt, 0);
            chk("cont_mem_a", mem_a, exp_if ? 64'h5 : 64'h6);
            chk("cont_if_rvalid", if_rvalid, 64'(prev_if));
            chk("cont_ls_rvalid", ls_rvalid, 64'(prev_ls));
            prev_if = exp_if;
            prev_ls = !exp_if;
        end

        // Starve clear: 3 denials, one cycle without IF request, then 4 more LS wins
        for (int i = 0; i < 3; i++) begin
            drive(1, 16'h0005, 1, 0, 16'h0006, 0);
            chk("clr_pre_ls_gnt", ls_gnt, 1);
        end
        drive(0, 16'h0005, 1, 0, 16'h0006, 0);
        chk("clr_gap_if_gnt", if_gnt, 0);
        chk("clr_gap_ls_gnt", ls_gnt, 1);
        for (int i = 0; i < 5; i++) begin
            drive(1, 16'h0005, 1, 0, 16'h0006, 0);
            chk("clr_if_gnt", if_gnt, 64'(i == 4));
            chk("clr_ls_gnt", ls_gnt, 64'(i != 4));
        end

        // Reset pulse while an IF read result is outstanding
        drive(1, 16'h0002, 0, 0, 0, 0);
        chk("rstrd_gnt", if_gnt, 1);
        @(posedge clk);
        #1;
        if_req = 1'b0;
        chk("rstrd_pre_rvalid", if_rvalid, 1);
        chk("rstrd_pre_rdata", if_rdata, 32'hA000_0002);
        reset = 1'b1;
        #1;
        chk("rstrd_if_rvalid", if_rvalid, 0);
        chk("rstrd_ls_rvalid", ls_rvalid, 0);
        reset = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        chk("rstrd_post_if_rvalid", if_rvalid, 0);
        chk("rstrd_post_ls_rvalid", ls_rvalid, 0);

        // Reset clears the starvation count while IF is being forced
        for (int i = 0; i < 4; i++) begin
            drive(1, 16'h0005, 1, 0, 16'h0006, 0);
            chk("rsts_ls_gnt", ls_gnt, 1);
        end
        drive(1, 16'h0005, 1, 0, 16'h0006, 0);
        chk("rsts_forced_if", if_gnt, 1);
        reset = 1'b1;
        #1;
        chk("rsts_clr_if_gnt", if_gnt, 0);
        chk("rsts_clr_ls_gnt", ls_gnt, 1);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1, 16'h0005, 1, 0, 16'h0006, 0);
            chk("rsts_post_ls_gnt", ls_gnt, 1);
        end
        drive(1, 16'h0005, 1, 0, 16'h0006, 0);
        chk("rsts_post_if_gnt", if_gnt, 1);

        // Alternating IF / LS-read requests
        drive(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 6; i++) begin
            if ((i % 2) == 0) begin
                drive(1, 16'h0001, 0, 0, 0, 0);
                chk("alt_if_gnt", if_gnt, 1);
            end else begin
                drive(0, 0, 1, 0, 16'h0012, 0);
                chk("alt_ls_gnt", ls_gnt, 1);
            end
            if (i % 2 == 1) begin
                chk("alt_if_rvalid", if_rvalid, 1);
                chk("alt_if_rdata", if_rdata, 32'hA000_0001);
                chk("alt_ls_rvalid_off", ls_rvalid, 0);
            end else if (i > 0) begin
                chk("alt_ls_rvalid", ls_rvalid, 1);
                chk("alt_ls_rdata", ls_rdata, 32'hDEADBEEF);
                chk("alt_if_rvalid_off", if_rvalid, 0);
            end
        end
        drive(0, 0, 0, 0, 0, 0);
        chk("alt_last_ls_rvalid", ls_rvalid, 1);
        chk("alt_last_ls_rdata", ls_rdata, 32'hDEADBEEF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
